// File: rtl/bus_write_arbiter_if.sv
// Requester-side handshake and shared register-bus signals of the write arbiter.
interface bus_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    io_req_valid;
  logic [NUM_REQ-1:0]    io_req_ready;
  logic [NUM_REQ-1:0]    io_req_lock;
  logic [4*NUM_REQ-1:0]  io_req_wen;
  logic [32*NUM_REQ-1:0] io_req_addr;
  logic [32*NUM_REQ-1:0] io_req_din;
  logic [3:0]            io_wen;
  logic [31:0]           io_addr;
  logic [31:0]           io_din;
  logic [IW-1:0]         io_grant_id;
  logic                  io_busy;

  modport master (
    output io_req_valid, io_req_lock, io_req_wen, io_req_addr, io_req_din,
    input  io_req_ready, io_wen, io_addr, io_din, io_grant_id, io_busy
  );

  modport slave (
    input  io_req_valid, io_req_lock, io_req_wen, io_req_addr, io_req_din,
    output io_req_ready, io_wen, io_addr, io_din, io_grant_id, io_busy
  );
endinterface

// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter sharing one registered write port among NUM_REQ requesters,
// with locked bursts of up to MAX_BURST writes and an optional idle gap per grant.
module bus_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic             io_clk,
  input logic             io_rst_n,
  bus_write_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  localparam state_t END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;
  localparam logic   END_BUSY  = (GAP_CYCLES > 0);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cur;
  logic [CW-1:0]   count;
  logic [3:0]      gap_cnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   ptr_next;
  logic            found;
  logic            xfer;
  logic [NUM_REQ-1:0] ready;

  logic [3:0]      wen_q;
  logic [31:0]     addr_q;
  logic [31:0]     din_q;
  logic [IW-1:0]   gid_q;
  logic            busy_q;

  always_comb begin
    int unsigned idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(ptr) + k) % NUM_REQ;
      cand = IW'(idx);
      if (!found && bus.io_req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Ready is combinational from valid, so it is masked by reset to stay low while held.
  always_comb begin
    ready = '0;
    if (io_rst_n) begin
      case (state)
        IDLE:    if (found) ready[win] = 1'b1;
        BURST:   ready[cur] = 1'b1;
        default: ready = '0;
      endcase
    end
  end

  assign xfer     = |(bus.io_req_valid & ready);
  assign sel      = (state == BURST) ? cur : win;
  assign ptr_next = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cur     <= '0;
      count   <= '0;
      gap_cnt <= '0;
      wen_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      wen_q <= '0;
      if (xfer) begin
        wen_q  <= bus.io_req_wen[{sel, 2'b00} +: 4];
        addr_q <= bus.io_req_addr[{sel, 5'b00000} +: 32];
        din_q  <= bus.io_req_din[{sel, 5'b00000} +: 32];
        gid_q  <= sel;
      end
      case (state)
        IDLE: begin
          if (xfer) begin
            ptr   <= ptr_next;
            cur   <= win;
            count <= CW'(1);
            if (bus.io_req_lock[win] && MAX_BURST > 1) begin
              state  <= BURST;
              busy_q <= 1'b1;
            end else begin
              state   <= END_STATE;
              busy_q  <= END_BUSY;
              gap_cnt <= 4'(GAP_CYCLES);
            end
          end
        end
        BURST: begin
          if (!bus.io_req_valid[cur]) begin
            state   <= END_STATE;
            busy_q  <= END_BUSY;
            gap_cnt <= 4'(GAP_CYCLES);
          end else begin
            count <= count + 1'b1;
            if (!bus.io_req_lock[cur] || count == CW'(MAX_BURST - 1)) begin
              state   <= END_STATE;
              busy_q  <= END_BUSY;
              gap_cnt <= 4'(GAP_CYCLES);
            end
          end
        end
        GAP: begin
          if (gap_cnt <= 4'd1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_req_ready = ready;
  assign bus.io_wen       = wen_q;
  assign bus.io_addr      = addr_q;
  assign bus.io_din       = din_q;
  assign bus.io_grant_id  = gid_q;
  assign bus.io_busy      = busy_q;
endmodule

// File: tb/tb_bus_write_arbiter.sv
// Scoreboard bench: two arbiters (no gap / 2-cycle gap) driven from per-requester write queues.
module tb_bus_write_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] din;
    logic        lock;
  } wr_t;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  gid;
    logic        busy;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    valid_v [2];
  logic [N-1:0]    lock_v  [2];
  logic [4*N-1:0]  wen_v   [2];
  logic [32*N-1:0] addr_v  [2];
  logic [32*N-1:0] din_v   [2];
  logic [N-1:0]    rdy_a   [2];
  bus_t            act     [2];

  bus_write_arbiter_if #(.NUM_REQ(N)) bif0 ();
  bus_write_arbiter_if #(.NUM_REQ(N)) bif1 ();

  bus_write_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .GAP_CYCLES(0)) dut0 (
    .io_clk(clk), .io_rst_n(rst_n), .bus(bif0));
  bus_write_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .GAP_CYCLES(2)) dut1 (
    .io_clk(clk), .io_rst_n(rst_n), .bus(bif1));

  assign bif0.io_req_valid = valid_v[0];
  assign bif0.io_req_lock  = lock_v[0];
  assign bif0.io_req_wen   = wen_v[0];
  assign bif0.io_req_addr  = addr_v[0];
  assign bif0.io_req_din   = din_v[0];
  assign bif1.io_req_valid = valid_v[1];
  assign bif1.io_req_lock  = lock_v[1];
  assign bif1.io_req_wen   = wen_v[1];
  assign bif1.io_req_addr  = addr_v[1];
  assign bif1.io_req_din   = din_v[1];
  assign rdy_a[0] = bif0.io_req_ready;
  assign rdy_a[1] = bif1.io_req_ready;
  assign act[0] = {bif0.io_wen, bif0.io_addr, bif0.io_din, bif0.io_grant_id, bif0.io_busy};
  assign act[1] = {bif1.io_wen, bif1.io_addr, bif1.io_din, bif1.io_grant_id, bif1.io_busy};

  wr_t          pend  [2][N][$];
  bus_t         exp_q [2][$];
  logic [N-1:0] exp_rdy [2];
  int           gap_p [2] = '{0, 2};
  int           owner [2];
  int           taken [2];
  int           gap_left [2];
  int           ptr_m [2];
  bus_t         last  [2];

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  bit rec = 1'b0;
  logic [1:0] gseq [$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic wr_t mk(input logic lock, input bit full);
    wr_t w;
    w.wen  = full ? 4'hF : (($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom));
    w.addr = $urandom;
    w.din  = $urandom;
    w.lock = lock;
    return w;
  endfunction

  task automatic drive(input int d);
    for (int i = 0; i < N; i++) begin
      if (pend[d][i].size() > 0) begin
        wr_t h = pend[d][i][0];
        valid_v[d][i]          = 1'b1;
        lock_v[d][i]           = h.lock;
        wen_v[d][i*4 +: 4]     = h.wen;
        addr_v[d][i*32 +: 32]  = h.addr;
        din_v[d][i*32 +: 32]   = h.din;
      end else begin
        valid_v[d][i]          = 1'b0;
        lock_v[d][i]           = 1'($urandom_range(0, 1));
        wen_v[d][i*4 +: 4]     = 4'($urandom);
        addr_v[d][i*32 +: 32]  = $urandom;
        din_v[d][i*32 +: 32]   = $urandom;
      end
    end
  endtask

  // Reference: a grant lasts while the owner keeps lock and valid, up to MB writes,
  // then gap_p idle cycles; fresh grants go to the first valid requester from the pointer.
  task automatic model(input int d);
    int x = -1;
    logic [N-1:0] r = '0;
    bus_t e;
    if (gap_left[d] > 0) begin
      gap_left[d]--;
    end else if (owner[d] >= 0) begin
      r[owner[d]] = 1'b1;
      if (valid_v[d][owner[d]]) begin
        x = owner[d];
        taken[d]++;
        if (!lock_v[d][x] || taken[d] == MB) begin
          owner[d] = -1;
          gap_left[d] = gap_p[d];
        end
      end else begin
        owner[d] = -1;
        gap_left[d] = gap_p[d];
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (x < 0 && valid_v[d][(ptr_m[d] + k) % N]) x = (ptr_m[d] + k) % N;
      if (x >= 0) begin
        r[x] = 1'b1;
        ptr_m[d] = (x + 1) % N;
        taken[d] = 1;
        if (lock_v[d][x] && MB > 1) owner[d] = x;
        else gap_left[d] = gap_p[d];
      end
    end
    if (x >= 0) begin
      wr_t it = pend[d][x].pop_front();
      last[d].wen  = it.wen;
      last[d].addr = it.addr;
      last[d].din  = it.din;
      last[d].gid  = 2'(x);
    end
    e = last[d];
    if (x < 0) e.wen = 4'h0;
    e.busy = (owner[d] >= 0) || (gap_left[d] > 0);
    exp_q[d].push_back(e);
    exp_rdy[d] = r;
  endtask

  task automatic step_all();
    for (int d = 0; d < 2; d++) drive(d);
    for (int d = 0; d < 2; d++) model(d);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    step_all();
  endtask

  function automatic bit idle();
    bit r = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (owner[d] >= 0 || gap_left[d] > 0) r = 1'b0;
      for (int i = 0; i < N; i++) if (pend[d][i].size() > 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic drain();
    int n = 0;
    while (n < 300 && !idle()) begin
      cycle();
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: queues still busy after %0d cycles, required empty", n);
    end
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      owner[d] = -1;
      taken[d] = 0;
      gap_left[d] = 0;
      ptr_m[d] = 0;
      last[d] = '0;
      drive(d);
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("reset_state_d%0d", d), {rdy_a[d], act[d]}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) exp_q[d].push_back('0);
    step_all();
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("ready_d%0d", d), rdy_a[d], exp_rdy[d]);
        if (exp_q[d].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL bus_d%0d: no expected entry queued, got %0h", d, act[d]);
        end else begin
          check($sformatf("bus_d%0d", d), act[d], exp_q[d].pop_front());
        end
      end
      if (rec && act[0].wen != 4'h0) gseq.push_back(act[0].gid);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [13:0] got;
    wr_t t2;
    for (int d = 0; d < 2; d++) begin
      valid_v[d] = '0; lock_v[d] = '0; wen_v[d] = '0; addr_v[d] = '0; din_v[d] = '0;
      exp_rdy[d] = '0;
    end

    // reset with every requester valid; first grant goes to requester 0
    for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) pend[d][i].push_back(mk(1'b0, 1'b1));
    do_reset();
    drain();

    // single write from requester 0
    t2.wen = 4'hF; t2.addr = 32'h10; t2.din = 32'hDEADBEEF; t2.lock = 1'b0;
    for (int d = 0; d < 2; d++) pend[d][0].push_back(t2);
    drain();

    // all requesters continuously valid, unlocked
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) repeat (8) pend[d][i].push_back(mk(1'b0, 1'b0));
    drain();

    // locked burst from requester 1 with requester 2 contending
    gseq.delete();
    rec = 1'b1;
    for (int d = 0; d < 2; d++) begin
      repeat (6) pend[d][1].push_back(mk(1'b1, 1'b1));
      repeat (3) pend[d][2].push_back(mk(1'b0, 1'b1));
    end
    drain();
    rec = 1'b0;
    got = '0;
    for (int i = 0; i < 7; i++) got = {got[11:0], (gseq.size() > i) ? gseq[i] : 2'b11};
    check("burst_order", 128'(got), 128'(14'b01_01_01_01_10_01_01));

    // requesters 0 and 3 continuously valid (exercises the gap on the second arbiter)
    for (int d = 0; d < 2; d++) begin
      repeat (6) pend[d][0].push_back(mk(1'b0, 1'b0));
      repeat (6) pend[d][3].push_back(mk(1'b0, 1'b0));
    end
    drain();

    // random traffic with random locks and occasional zero byte enables
    repeat (400) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++)
          if (pend[d][i].size() < 4 && $urandom_range(0, 99) < 35)
            pend[d][i].push_back(mk(1'($urandom_range(0, 1)), 1'b0));
      cycle();
    end
    drain();

    // asynchronous reset while requester 2 is two writes into a burst
    for (int d = 0; d < 2; d++) repeat (4) pend[d][2].push_back(mk(1'b1, 1'b1));
    repeat (3) cycle();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("async_rst_d%0d", d), {rdy_a[d], act[d].wen, act[d].busy}, '0);
    for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) pend[d][i].delete();
    for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) pend[d][i].push_back(mk(1'b0, 1'b1));
    do_reset();
    drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bus_write_arbiter.md
Name: bus_write_arbiter

Overview:
- Round-robin arbiter sharing the single-write-port register bus (io_wen/io_addr/io_din) between NUM_REQ requesters.
- Drives the bus consumed by the address-catch register blocks.
- Supports locked bursts of up to MAX_BURST writes per grant and an optional idle gap between grants.
- Bus outputs are registered; one accepted request produces exactly one bus write cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum transfers per grant when lock is held (1..16).
- GAP_CYCLES, 0, idle cycles forced after each grant ends (0..15).

Ports:
- io_clk  input  1  clock; all logic on rising edge.
- io_rst_n  input  1  asynchronous, active-low reset.
- io_req_valid  input  NUM_REQ  per-requester write request.
- io_req_ready  output  NUM_REQ  per-requester accept; a transfer occurs when valid&ready.
- io_req_lock  input  NUM_REQ  keep the grant for the next transfer (burst).
- io_req_wen  input  4*NUM_REQ  byte enables; requester i uses bits [4i+:4].
- io_req_addr  input  32*NUM_REQ  byte address; requester i uses bits [32i+:32].
- io_req_din  input  32*NUM_REQ  write data; requester i uses bits [32i+:32].
- io_wen  output  4  bus byte enables; nonzero for exactly one cycle per transfer.
- io_addr  output  32  bus address.
- io_din  output  32  bus write data.
- io_grant_id  output  clog2(NUM_REQ)  index of the requester whose write is on the bus.
- io_busy  output  1  high in BURST or GAP state.

Behaviour:
- Reset (async, while io_rst_n=0):
  - io_wen=0, io_addr=0, io_din=0, io_grant_id=0, io_busy=0, io_req_ready=0.
  - State IDLE; rr pointer=0; burst count=0.
  - Reset mid-burst drops the grant and any unissued write. io_wen goes to 0 immediately.
- FSM states: IDLE, BURST, GAP.
- IDLE:
  - Winner = first i with valid[i]=1, scanning ptr, ptr+1, … mod NUM_REQ.
  - io_req_ready[winner]=1 in the same cycle (combinational from valid). All other ready bits are 0.
  - On transfer: ptr<=winner+1 mod NUM_REQ; cur<=winner; count<=1.
  - Next state after a transfer:
    - BURST if lock[winner]=1 and MAX_BURST>1;
    - else GAP if GAP_CYCLES>0;
    - else stay in IDLE, re-arbitrating on the next cycle.
  - No valid: stay in IDLE, all ready=0.
- BURST:
  - io_req_ready[cur]=1 only; count increments per transfer.
  - Grant ends (to GAP if GAP_CYCLES>0, else IDLE) on any of:
    - a transfer with lock[cur]=0;
    - a transfer that makes count=MAX_BURST;
    - a cycle with valid[cur]=0. No transfer happens that cycle; the grant is released.
  - Other requesters are never granted while in BURST.
- GAP:
  - All ready=0. Down-counter loads GAP_CYCLES on entry.
  - Return to IDLE after exactly GAP_CYCLES cycles in GAP.
- Bus timing:
  - A transfer in cycle N gives io_wen/io_addr/io_din/io_grant_id = the accepted values in cycle N+1.
  - io_wen=0 in any cycle following a non-transfer cycle.
  - io_addr, io_din and io_grant_id hold their last values when there is no transfer.
- A transfer with io_req_wen=0 is still accepted and counted; it produces io_wen=0 on the bus.
- Requesters must not make valid depend on ready. Once valid is asserted, wen/addr/din/lock must be held stable until the transfer.
- Throughput: with GAP_CYCLES=0, one transfer per cycle is sustained, both across back-to-back IDLE grants and within a burst.
- Width rules:
  - ptr and cur are clog2(NUM_REQ) bits and wrap at NUM_REQ (for a non-power-of-2 NUM_REQ, NUM_REQ-1 wraps to 0).
  - count is clog2(MAX_BURST+1) bits.

Test Plan:
1. Hold io_rst_n=0 with all valid high.
   -> ready=0, io_wen=0, io_addr=0, io_din=0, io_busy=0. After release, first grant goes to requester 0.
2. Requester 0: valid=1, wen=4'hF, addr=32'h10, din=32'hDEADBEEF, lock=0 in cycle N.
   -> ready[0]=1 in cycle N.
   -> Cycle N+1: io_wen=F, io_addr=0x10, io_din=0xDEADBEEF, io_grant_id=0.
   -> Cycle N+2: io_wen=0.
3. All 4 requesters valid every cycle, lock=0, GAP_CYCLES=0.
   -> io_grant_id sequence 0,1,2,3,0,1… with one write per cycle and no io_wen=0 holes.
4. MAX_BURST=4. Requester 1 has lock=1 and 6 queued writes; requester 2 is valid throughout.
   -> Writes 1,1,1,1,2,1,1 in that order; io_busy=1 during the requester-1 burst.
5. GAP_CYCLES=2. Requesters 0 and 3 valid continuously, lock=0.
   -> Writes 0, then 2 cycles with io_wen=0 and ready=0, then 3, then 2 idle cycles, then 0.
6. Requester 2 is mid-burst (count=2) and io_rst_n drops asynchronously between clock edges.
   -> io_wen=0 and io_busy=0 immediately. After release, the state is IDLE and arbitration restarts from ptr=0.
